// File: rtl/wb_pkg.sv
`default_nettype none
// wb_pkg: shared types and constants for the Wishbone classic-cycle initiator.
// Rev 1.0
package wb_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [1:0] WB_OK      = 2'b00;
  localparam logic [1:0] WB_ERR     = 2'b01;
  localparam logic [1:0] WB_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// wb_timeout_counter: saturating wait-cycle counter; expired flags the last allowed cycle.
// Rev 1.0
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // A zero timeout disables expiry entirely; the counter then just saturates.
  assign expired = ENABLED && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// wb_initiator: single-transaction Wishbone classic-cycle initiator with
// valid/ready command and response ports and an optional ack/err timeout.
// Rev 1.0
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic [1:0]          rsp_status,
  output logic                busy,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i
);

  wb_state_t state;

  logic                ack_seen;
  logic                err_seen;
  logic                expired;
  logic                done;
  logic [1:0]          done_status;
  logic [WB_DAT_W-1:0] done_dat;

  assign ack_seen = wbm_stb_o & wbm_ack_i;
  assign err_seen = wbm_stb_o & wbm_err_i;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != BUS),
    .enable ((state == BUS) && !ack_seen && !err_seen),
    .expired(expired)
  );

  // err wins over a simultaneous ack; only an acked read returns data.
  always_comb begin
    done        = 1'b0;
    done_status = WB_OK;
    done_dat    = '0;
    if (err_seen) begin
      done        = 1'b1;
      done_status = WB_ERR;
    end else if (ack_seen) begin
      done        = 1'b1;
      done_status = WB_OK;
      done_dat    = wbm_we_o ? '0 : wbm_dat_i;
    end else if (expired) begin
      done        = 1'b1;
      done_status = WB_TIMEOUT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= WB_OK;
      busy       <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            state     <= BUS;
          end
        end
        BUS: begin
          if (done) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_status <= done_status;
            rsp_dat    <= done_dat;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// tb_wb_initiator: directed self-checking bench for wb_initiator (timeout 4 and timeout disabled).
// Rev 1.0
module tb_wb_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        cmd_ready, rsp_valid, rsp_ready, busy;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        ack, err;

  // Second instance with the timeout disabled; the responder never answers it.
  logic        cmd_valid0, cmd_ready0, rsp_valid0, rsp_ready0, busy0;
  logic [31:0] rsp_dat0;
  logic [1:0]  rsp_status0;
  logic        cyc0, stb0, we0;
  logic [31:0] adr0, wdat0;
  logic [3:0]  sel0;
  logic        ack0 = 1'b0;
  logic        err0 = 1'b0;
  logic [31:0] rdat0 = 32'h0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  wb_initiator #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .busy(busy),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_err_i(err),
    .wbm_dat_i(rdat)
  );

  wb_initiator #(.TIMEOUT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_dat(rsp_dat0),
    .rsp_status(rsp_status0), .busy(busy0),
    .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_we_o(we0), .wbm_adr_o(adr0),
    .wbm_dat_o(wdat0), .wbm_sel_o(sel0), .wbm_ack_i(ack0), .wbm_err_i(err0),
    .wbm_dat_i(rdat0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; err = 1'b0; rdat = '0;
    cmd_valid0 = 1'b0; rsp_ready0 = 1'b0;
    tick(); tick();

    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp", {rsp_dat ^ 32'(rsp_status)}, 32'd0);
    check("rst_bus_regs", adr | wdat | 32'(sel) | 32'(we) | 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write, responder acks in the third stb cycle.
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    check("wr_cyc_stb", {30'd0, cyc, stb}, 32'd3);
    check("wr_busy_ready", {30'd0, busy, cmd_ready}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("wr_adr_stable", adr, 32'h3000_0004);
      check("wr_dat_stable", wdat, 32'hDEAD_BEEF);
      check("wr_we_sel_stb", {26'd0, stb, we, sel}, {26'd0, 1'b1, 1'b1, 4'hF});
      if (i == 2) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_cyc_low", {30'd0, cyc, stb}, 32'd0);
    check("wr_status", 32'(rsp_status), 32'd0);
    check("wr_rsp_dat", rsp_dat, 32'd0);
    drain();
    check("wr_back_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);

    // Read, zero-wait responder.
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    ack = 1'b1; rdat = 32'h1234_5678;
    check("rd_adr_we", {adr[30:0], we}, {31'h3000_0008 >> 0, 1'b0});
    check("rd_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    ack = 1'b0; rdat = 32'h0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_dat", rsp_dat, 32'h1234_5678);
    check("rd_status", 32'(rsp_status), 32'd0);
    drain();

    // ack and err together: err wins.
    issue(1'b0, 32'h3000_000C, 32'h0, 4'h3);
    ack = 1'b1; err = 1'b1; rdat = 32'hFFFF_FFFF;
    tick();
    ack = 1'b0; err = 1'b0; rdat = 32'h0;
    check("err_status", 32'(rsp_status), 32'd1);
    check("err_rsp_dat", rsp_dat, 32'd0);
    drain();

    // Timeout of 4: stb high exactly four cycles.
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    n = stb ? 1 : 0;
    for (int i = 0; i < 10 && stb; i++) begin
      tick();
      if (stb) n++;
    end
    check("to_stb_cycles", 32'(n), 32'd4);
    check("to_cyc_low", {30'd0, cyc, stb}, 32'd0);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_status", 32'(rsp_status), 32'd2);
    check("to_rsp_dat", rsp_dat, 32'd0);
    drain();

    // Timeout disabled: stb stays high for 1000 cycles.
    cmd_valid0 = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020;
    tick();
    cmd_valid0 = 1'b0;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!stb0 || !cyc0 || rsp_valid0) n++;
      tick();
    end
    check("nto_stb_dropouts", 32'(n), 32'd0);

    // Back-pressure on the response with a new command pending.
    issue(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    ack = 1'b1; rdat = 32'hCAFE_0001;
    tick();
    ack = 1'b0; rdat = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0018; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready || !rsp_valid || rsp_dat != 32'hCAFE_0001 || rsp_status != 2'b00 || cyc) n++;
      tick();
    end
    check("bp_hold_cycles_bad", 32'(n), 32'd0);
    check("bp_rsp_dat", rsp_dat, 32'hCAFE_0001);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_ready_after", {29'd0, cmd_ready, rsp_valid, cyc}, 32'd4);
    tick();
    cmd_valid = 1'b0;
    check("bp_second_accept", {30'd0, cyc, we}, 32'd3);
    check("bp_second_adr", adr, 32'h3000_0018);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("bp_second_rsp", {29'd0, rsp_valid, rsp_status}, 32'd4);
    drain();

    // Stray ack/err while idle.
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    check("stray_state", {28'd0, cmd_ready, rsp_valid, busy, cyc}, 32'd8);
    check("stray_status", 32'(rsp_status), 32'd0);

    // Reset in the second BUS cycle.
    issue(1'b0, 32'h3000_001C, 32'h0, 4'hF);
    tick();
    check("mr_in_bus", 32'(stb), 32'd1);
    reset = 1'b1;
    tick();
    check("mr_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("mr_rsp_ready", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    tick();
    check("mr_ready_held", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid || cyc) n++;
    end
    check("mr_no_response", 32'(n), 32'd0);
    check("mr_ready_back", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
